// File: rtl/systolic_array_streamer_if.sv
// OBI request/response bundle shared by the streamer's read and write ports.
// Ports (per modport):
//   master: drives req, we, be, addr, wdata; samples gnt, rvalid, rdata
//   slave : samples req, we, be, addr, wdata; drives gnt, rvalid, rdata
interface systolic_array_streamer_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/systolic_array_streamer.sv
// OBI master that copies a block of 32-bit words from system memory into the
// systolic-array wrapper's command window. Word k is read from src + 4*k and
// written to SA_BASE_ADDR | (cmd << 18) | (idx << 2), idx = k mod SA_SIZE.
// Ports:
//   clk_i        clock
//   rst_n        synchronous active-low reset
//   start_i      start pulse, honoured only when idle
//   src_addr_i   word-aligned address of the first source word
//   num_words_i  number of words to move (0 = immediate completion)
//   cmd_i        wrapper command encoded into every write address
//   busy_o       high in every state except idle
//   done_o       one-cycle completion pulse
//   mem          OBI read master toward memory
//   sa           OBI write master toward the wrapper
module systolic_array_streamer #(
  parameter int unsigned SA_SIZE      = 4,
  parameter logic [31:0] SA_BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [31:0]                src_addr_i,
  input  logic [15:0]                num_words_i,
  input  logic [1:0]                 cmd_i,
  output logic                       busy_o,
  output logic                       done_o,
  systolic_array_streamer_if.master  mem,
  systolic_array_streamer_if.master  sa
);

  localparam int unsigned IDX_W = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e             state_r, state_s;
  logic [15:0]        k_r, k_s;
  logic [15:0]        n_r, n_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [31:0]        src_r, src_s;
  logic [1:0]         cmd_r, cmd_s;
  logic [31:0]        data_r, data_s;

  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               mem_req_r, mem_req_s;
  logic [3:0]         mem_be_r, mem_be_s;
  logic [31:0]        mem_addr_r, mem_addr_s;
  logic               sa_req_r, sa_req_s;
  logic               sa_we_r, sa_we_s;
  logic [3:0]         sa_be_r, sa_be_s;
  logic [31:0]        sa_addr_r, sa_addr_s;
  logic [31:0]        sa_wdata_r, sa_wdata_s;
  logic               last_word_s;

  // Write responses carry no data of interest; fold them into a sink.
  logic sa_rdata_unused;
  assign sa_rdata_unused = ^sa.rdata;

  // k counts completed words; compare at 17 bits so N = 65535 cannot wrap.
  assign last_word_s = (({1'b0, k_r} + 17'd1) == {1'b0, n_r});

  // Next-state and transfer-context update.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    n_s     = n_r;
    idx_s   = idx_r;
    src_s   = src_r;
    cmd_s   = cmd_r;
    data_s  = data_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          src_s   = src_addr_i;
          n_s     = num_words_i;
          cmd_s   = cmd_i;
          k_s     = 16'd0;
          idx_s   = '0;
          state_s = (num_words_i == 16'd0) ? S_DONE : S_RD_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (mem.gnt) state_s = S_RD_WAIT;
        else         state_s = S_RD_REQ;
      end
      S_RD_WAIT: begin
        if (mem.rvalid) begin
          data_s  = mem.rdata;
          state_s = S_WR_REQ;
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_WR_REQ: begin
        if (sa.gnt) state_s = S_WR_WAIT;
        else        state_s = S_WR_REQ;
      end
      S_WR_WAIT: begin
        if (sa.rvalid) begin
          k_s     = k_r + 16'd1;
          idx_s   = idx_r + IDX_W'(1);
          state_s = last_word_s ? S_DONE : S_RD_REQ;
        end else begin
          state_s = S_WR_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so that
  // every bus field is a flop and stays steady while a request waits for gnt.
  always_comb begin
    busy_s     = (state_s != S_IDLE);
    done_s     = (state_s == S_DONE);
    mem_req_s  = (state_s == S_RD_REQ);
    sa_req_s   = (state_s == S_WR_REQ);
    mem_be_s   = 4'h0;
    mem_addr_s = 32'h0000_0000;
    sa_we_s    = 1'b0;
    sa_be_s    = 4'h0;
    sa_addr_s  = 32'h0000_0000;
    sa_wdata_s = 32'h0000_0000;
    if (mem_req_s) begin
      mem_be_s   = 4'hF;
      mem_addr_s = src_s + {14'd0, k_s, 2'b00};
    end else begin
      mem_be_s   = 4'h0;
    end
    if (sa_req_s) begin
      sa_we_s    = 1'b1;
      sa_be_s    = 4'hF;
      sa_addr_s  = SA_BASE_ADDR | {12'd0, cmd_s, 18'd0}
                 | {{(30 - IDX_W){1'b0}}, idx_s, 2'b00};
      sa_wdata_s = data_s;
    end else begin
      sa_we_s    = 1'b0;
    end
  end

  // State, transfer context and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      k_r        <= 16'd0;
      n_r        <= 16'd0;
      idx_r      <= '0;
      src_r      <= 32'h0000_0000;
      cmd_r      <= 2'd0;
      data_r     <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_be_r   <= 4'h0;
      mem_addr_r <= 32'h0000_0000;
      sa_req_r   <= 1'b0;
      sa_we_r    <= 1'b0;
      sa_be_r    <= 4'h0;
      sa_addr_r  <= 32'h0000_0000;
      sa_wdata_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      k_r        <= k_s;
      n_r        <= n_s;
      idx_r      <= idx_s;
      src_r      <= src_s;
      cmd_r      <= cmd_s;
      data_r     <= data_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      mem_req_r  <= mem_req_s;
      mem_be_r   <= mem_be_s;
      mem_addr_r <= mem_addr_s;
      sa_req_r   <= sa_req_s;
      sa_we_r    <= sa_we_s;
      sa_be_r    <= sa_be_s;
      sa_addr_r  <= sa_addr_s;
      sa_wdata_r <= sa_wdata_s;
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign mem.req   = mem_req_r;
  assign mem.we    = 1'b0;
  assign mem.be    = mem_be_r;
  assign mem.addr  = mem_addr_r;
  assign mem.wdata = 32'h0000_0000;
  assign sa.req    = sa_req_r;
  assign sa.we     = sa_we_r;
  assign sa.be     = sa_be_r;
  assign sa.addr   = sa_addr_r;
  assign sa.wdata  = sa_wdata_r;

endmodule

// File: doc/systolic_array_streamer.md
# systolic_array_streamer

OBI master that moves a block of 32-bit words from system memory into the TicSAT systolic-array wrapper without CPU involvement. Each source word becomes one write to the wrapper's command window, at offset ((CMD << 18) | (IDX << 2)); IDX cycles modulo the array size. The block sits directly upstream of the systolic-array wrapper. Its read port goes to the system crossbar; its write port goes to the wrapper's OBI slave.

## Interface
Parameters:
- SA_SIZE, default heepstor_pkg::SYSTOLIC_ARRAY_SIZE: systolic-array dimension. Must be a power of two, ≥2.
- SA_BASE_ADDR, default 32'h0: base of the wrapper's 1 MiB window. Bits [19:0] must be 0.

Ports:
- clk_i  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start_i  input  1  one-cycle start pulse; sampled only in IDLE
- src_addr_i  input  32  word-aligned source address of the first word
- num_words_i  input  16  number of words to transfer
- cmd_i  input  2  TicSAT command_t used for every write
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle completion pulse
- mem_req_o  output  obi_req_t  read master toward memory
- mem_resp_i  input  obi_resp_t  read response
- sa_req_o  output  obi_req_t  write master toward the wrapper
- sa_resp_i  input  obi_resp_t  write response

## Operation
- On start_i in IDLE, latch src_addr_i, num_words_i and cmd_i. Clear word counter k and index idx.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
  - IDLE → RD_REQ on start with num_words ≠ 0. IDLE → DONE on start with num_words = 0; no bus traffic occurs.
  - RD_REQ: mem req=1, we=0, be=4'hF, addr = src + 4·k (32-bit wrap). Go to RD_WAIT on mem gnt.
  - RD_WAIT: on mem rvalid, latch rdata into data_q and go to WR_REQ.
  - WR_REQ: sa req=1, we=1, be=4'hF, wdata = data_q, addr = SA_BASE_ADDR | (cmd << 18) | (idx << 2). Go to WR_WAIT on sa gnt.
  - WR_WAIT: on sa rvalid, increment k and set idx = (idx+1) mod SA_SIZE. If k+1 = num_words go to DONE, else go to RD_REQ.
  - DONE: assert done_o for one cycle, then return to IDLE.
- One outstanding transaction per port. The two ports are never active at the same time.
- cmd_i = CMD_NONE (0) is not special-cased: the writes are issued, and the wrapper ignores them.
- start_i outside IDLE is ignored. Input changes after the latch have no effect.
- rdata from sa_resp_i is ignored.

## Timing
- Reset values: busy_o=0, done_o=0, and all req/we/be/addr/wdata fields of both request ports = 0. State → IDLE; k, idx, data_q → 0.
- Reset mid-transfer: in the next cycle all outputs hold their reset values. Outstanding responses are dropped, and no done_o is issued.
- OBI rule: once req is high, addr/we/be/wdata stay stable until the gnt cycle. req falls in the cycle after gnt.
- busy_o = 1 in every state except IDLE, including the DONE cycle.
- With zero-wait slaves (gnt in the req cycle, rvalid one cycle later) each word costs 4 cycles:
  - RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - done_o rises 1 cycle after the final sa rvalid.
  - Total from start to done_o = 4·N + 1 cycles.
- num_words = 0: done_o is high in cycle start+1.
- num_words = 65535 completes normally. k is 16 bits and never wraps before completion.
- Wait states on gnt or rvalid only stretch the corresponding state.

## Test plan
- N=4, cmd=CMD_QUEUE(1), SA_SIZE=4, src=0x1000, memory holds 0xA0..0xA3 → four writes:
  - offsets 0x40000, 0x40004, 0x40008, 0x4000C;
  - wdata 0xA0..0xA3;
  - done_o at cycle 17.
- N=6, SA_SIZE=4, cmd=CMD_STREAM(2) → idx sequence 0,1,2,3,0,1; write addresses base|0x80000|{0,4,8,C,0,4}.
- N=0 → no req on either port; busy_o=1 and done_o=1 in cycle start+1; IDLE afterwards.
- Random gnt delays 0–5 cycles and rvalid delays 1–5 cycles on both ports, N=16 → request fields stable while ungranted, data order preserved, exactly 16 writes, one done_o.
- start_i re-pulsed during a busy N=8 transfer → ignored; exactly 8 writes.
- rst_n low during WR_REQ of word 2 → next cycle sa req=0, mem req=0, busy_o=0. A new start then transfers from word 0.
